// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB register-bank slave.
package apb_pkg;
  localparam int         APB_ADDR_W    = 8;
  localparam int         APB_DATA_W    = 8;
  localparam logic [7:0] APB_RESET_VAL = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;
endpackage

// File: rtl/apb_wait_ctr.sv
// ACCESS-phase wait counter: loads on SETUP, counts down during ACCESS, saturates at zero.
module apb_wait_ctr
  import apb_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_cnt_zero
);
  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(WAIT_CYCLES);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt_zero = (r_cnt == '0);
endmodule

// File: rtl/apb_slave_regbank.sv
// APB slave with DEPTH read/write registers, optional fixed wait states,
// PSLVERR on out-of-range addresses and a sticky master protocol-violation flag.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int                ADDR_W      = APB_ADDR_W,
  parameter int                DATA_W      = APB_DATA_W,
  parameter int                DEPTH       = 16,
  parameter int                WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0] RESET_VAL   = DATA_W'(APB_RESET_VAL)
) (
  input  logic                    i_pclk,
  input  logic                    i_prst,
  input  logic                    i_psel,
  input  logic                    i_penable,
  input  logic                    i_pwrite,
  input  logic [ADDR_W-1:0]       i_paddr,
  input  logic [DATA_W-1:0]       i_pwdata,
  output logic [DATA_W-1:0]       o_prdata,
  output logic                    o_pready,
  output logic                    o_pslverr,
  output logic [DEPTH*DATA_W-1:0] o_reg_q,
  output logic                    o_proto_err
);
  // state  | meaning (bus phase seen on the previous edge)
  // IDLE   | psel low; an ACCESS phase now is a violation
  // SETUP  | setup phase; an ACCESS phase must follow now
  // ACCESS | access phase; if it stalled, controls must be unchanged now
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_state_e        r_state;
  logic              r_stall;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_proto_err;
  logic [DATA_W-1:0] r_regs [DEPTH];

  logic              w_setup;
  logic              w_access;
  logic              w_cnt_zero;
  logic              w_pready;
  logic              w_addr_ok;
  logic [IDX_W-1:0]  w_idx;
  logic              w_ctrl_changed;
  logic              w_proto_viol;

  assign w_setup   = i_psel && !i_penable;
  assign w_access  = i_psel && i_penable;
  assign w_pready  = w_access && w_cnt_zero && !i_prst;
  assign w_addr_ok = (32'(i_paddr) < DEPTH);
  assign w_idx     = i_paddr[IDX_W-1:0];

  assign w_ctrl_changed = (i_paddr != r_paddr) || (i_pwrite != r_pwrite) ||
                          (i_pwdata != r_pwdata);
  assign w_proto_viol   = ((r_state == IDLE)   && w_access) ||
                          ((r_state == SETUP)  && !w_access) ||
                          ((r_state == ACCESS) && r_stall && w_ctrl_changed);

  apb_wait_ctr #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_ctr (
    .i_clk      (i_pclk),
    .i_rst      (i_prst),
    .i_load     (w_setup),
    .i_dec      (w_access),
    .o_cnt_zero (w_cnt_zero)
  );

  always_ff @(posedge i_pclk or posedge i_prst) begin
    if (i_prst) begin
      r_state     <= IDLE;
      r_stall     <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (!i_psel) begin
        r_state <= IDLE;
      end else if (!i_penable) begin
        r_state <= SETUP;
      end else begin
        r_state <= ACCESS;
      end
      r_stall  <= w_access && !w_pready;
      r_paddr  <= i_paddr;
      r_pwrite <= i_pwrite;
      r_pwdata <= i_pwdata;
      if (w_proto_viol) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_pclk or posedge i_prst) begin
    if (i_prst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else if (w_pready && i_pwrite && w_addr_ok) begin
      r_regs[w_idx] <= i_pwdata;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_reg_q
    assign o_reg_q[g*DATA_W +: DATA_W] = r_regs[g];
  end

  // Read data is address-driven from SETUP on, so it is already stable at completion.
  assign o_prdata    = (i_psel && !i_pwrite && w_addr_ok && !i_prst) ? r_regs[w_idx] : '0;
  assign o_pready    = w_pready;
  assign o_pslverr   = w_pready && !w_addr_ok;
  assign o_proto_err = r_proto_err;
endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: instances with 0, 2 and 3 wait states share one
// APB bus (separate psel each); a reference model feeds an expected-result queue.
module tb_apb_slave_regbank;
  import apb_pkg::*;

  typedef struct packed {
    logic [7:0] rd;
    logic       err;
    logic [7:0] cycles;
  } exp_t;

  logic         clk;
  logic         rst0, rst3;
  logic         psel0, psel2, psel3, penable, pwrite;
  logic [7:0]   paddr, pwdata;
  logic [7:0]   prdata0, prdata2, prdata3;
  logic         pready0, pready2, pready3;
  logic         pslverr0, pslverr2, pslverr3;
  logic         proto0, proto2, proto3;
  logic [127:0] regq0, regq2, regq3;

  int           cur;
  int           total;
  int           bad;
  logic [7:0]   model [4][16];
  exp_t         exp_q [$];

  logic [7:0]   s_prdata;
  logic         s_pready, s_pslverr, s_proto;
  logic [127:0] s_regq;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  apb_slave_regbank #(.WAIT_CYCLES(0)) u_dut0 (
    .i_pclk(clk), .i_prst(rst0), .i_psel(psel0), .i_penable(penable),
    .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata),
    .o_prdata(prdata0), .o_pready(pready0), .o_pslverr(pslverr0),
    .o_reg_q(regq0), .o_proto_err(proto0)
  );

  apb_slave_regbank #(.WAIT_CYCLES(2)) u_dut2 (
    .i_pclk(clk), .i_prst(rst0), .i_psel(psel2), .i_penable(penable),
    .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata),
    .o_prdata(prdata2), .o_pready(pready2), .o_pslverr(pslverr2),
    .o_reg_q(regq2), .o_proto_err(proto2)
  );

  apb_slave_regbank #(.WAIT_CYCLES(3)) u_dut3 (
    .i_pclk(clk), .i_prst(rst3), .i_psel(psel3), .i_penable(penable),
    .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata),
    .o_prdata(prdata3), .o_pready(pready3), .o_pslverr(pslverr3),
    .o_reg_q(regq3), .o_proto_err(proto3)
  );

  always_comb begin
    s_prdata  = prdata0;
    s_pready  = pready0;
    s_pslverr = pslverr0;
    s_proto   = proto0;
    s_regq    = regq0;
    if (cur == 2) begin
      s_prdata = prdata2; s_pready = pready2; s_pslverr = pslverr2;
      s_proto  = proto2;  s_regq   = regq2;
    end else if (cur == 3) begin
      s_prdata = prdata3; s_pready = pready3; s_pslverr = pslverr3;
      s_proto  = proto3;  s_regq   = regq3;
    end
  end

  function automatic logic [127:0] model_flat(input int d);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = model[d][i];
    return v;
  endfunction

  task automatic sb_push(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    exp_t e;
    e.err    = (addr >= 8'd16);
    e.rd     = (!wr && addr < 8'd16) ? model[cur][addr[3:0]] : 8'h00;
    e.cycles = 8'(2 + cur);
    if (wr && addr < 8'd16) model[cur][addr[3:0]] = data;
    exp_q.push_back(e);
  endtask

  task automatic set_sel(input logic v);
    psel0 = v && (cur == 0);
    psel2 = v && (cur == 2);
    psel3 = v && (cur == 3);
  endtask

  // Starts at posedge+1, returns at posedge+1 after the completion edge.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                      output logic [7:0] rd_setup, output logic [7:0] rd,
                      output logic err, output logic [7:0] cycles,
                      output logic [127:0] q_done);
    logic done;
    done = 1'b0; rd = 8'h00; err = 1'b0; q_done = '0; cycles = 8'd1;
    set_sel(1'b1); penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(negedge clk);
    rd_setup = s_prdata;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      cycles++;
      @(negedge clk);
      if (s_pready) begin
        done = 1'b1; rd = s_prdata; err = s_pslverr; q_done = s_regq;
      end
      @(posedge clk); #1;
    end
    set_sel(1'b0); penable = 1'b0;
    if (!done) begin
      $display("FAIL xfer_timeout: pready never rose, addr=%h want completion", addr);
      bad++; total++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] rs, rd, cyc; logic er; logic [127:0] qd; exp_t e;
    cur = 0;
    rst0 = 1'b1; rst3 = 1'b1;
    psel0 = 1'b0; psel2 = 1'b0; psel3 = 1'b0;
    penable = 1'b0; pwrite = 1'b0; paddr = 8'h03; pwdata = 8'h00;
    for (int d = 0; d < 4; d++) for (int i = 0; i < 16; i++) model[d][i] = 8'h00;
    repeat (2) @(posedge clk); #1;
    set_sel(1'b1); penable = 1'b1;
    @(negedge clk);
    total++;
    if ({s_pready, s_pslverr, s_prdata} !== 10'h000) begin
      $display("FAIL reset_outputs: got pready=%b pslverr=%b prdata=%h want 0 0 00",
               s_pready, s_pslverr, s_prdata);
      bad++;
    end
    set_sel(1'b0); penable = 1'b0;
    @(posedge clk); #1;
    rst0 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    total++;
    if (s_regq !== model_flat(0)) begin
      $display("FAIL reset_regq: got %h want %h", s_regq, model_flat(0)); bad++;
    end
    total++;
    if (s_proto !== 1'b0) begin
      $display("FAIL reset_proto: got %b want 0", s_proto); bad++;
    end
    @(posedge clk); #1;
    sb_push(1'b0, 8'h03, 8'h00);
    xfer(1'b0, 8'h03, 8'h00, rs, rd, er, cyc, qd);
    e = exp_q.pop_front();
    total++;
    if (rd !== e.rd) begin $display("FAIL read3_data: got %h want %h", rd, e.rd); bad++; end
    total++;
    if (cyc !== e.cycles) begin $display("FAIL read3_cycles: got %0d want %0d", cyc, e.cycles); bad++; end
    total++;
    if (er !== e.err) begin $display("FAIL read3_err: got %b want %b", er, e.err); bad++; end
    @(negedge clk);
    total++;
    if (s_proto !== 1'b0) begin $display("FAIL read3_proto: got %b want 0", s_proto); bad++; end
  endtask

  task automatic test_write_read();
    logic [7:0] rs, rd, cyc; logic er; logic [127:0] qd; exp_t e;
    @(posedge clk); #1;
    cur = 0;
    sb_push(1'b1, 8'h05, 8'hA5);
    xfer(1'b1, 8'h05, 8'hA5, rs, rd, er, cyc, qd);
    e = exp_q.pop_front();
    total++;
    if ({er, cyc} !== {e.err, e.cycles}) begin
      $display("FAIL wr5_resp: got err=%b cyc=%0d want err=%b cyc=%0d", er, cyc, e.err, e.cycles); bad++;
    end
    @(negedge clk);
    total++;
    if (s_regq[47:40] !== model[0][5]) begin
      $display("FAIL wr5_regq: got %h want %h", s_regq[47:40], model[0][5]); bad++;
    end
    total++;
    if (s_regq !== model_flat(0)) begin
      $display("FAIL wr5_regq_all: got %h want %h", s_regq, model_flat(0)); bad++;
    end
    @(posedge clk); #1;
    sb_push(1'b0, 8'h05, 8'h00);
    xfer(1'b0, 8'h05, 8'h00, rs, rd, er, cyc, qd);
    e = exp_q.pop_front();
    total++;
    if (rs !== e.rd) begin $display("FAIL rd5_setup: got %h want %h", rs, e.rd); bad++; end
    total++;
    if ({rd, er, cyc} !== {e.rd, e.err, e.cycles}) begin
      $display("FAIL rd5_access: got %h/%b/%0d want %h/%b/%0d", rd, er, cyc, e.rd, e.err, e.cycles); bad++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] tw [5] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00};
    logic [7:0] ta [5] = '{8'h07, 8'h07, 8'h0F, 8'h0F, 8'h10};
    logic [7:0] td [5] = '{8'h5A, 8'h00, 8'hC3, 8'h00, 8'h00};
    logic [7:0] rs, rd, cyc; logic er; logic [127:0] qd; exp_t e;
    @(posedge clk); #1;
    cur = 0;
    for (int i = 0; i < 5; i++) begin
      sb_push(tw[i][0], ta[i], td[i]);
      xfer(tw[i][0], ta[i], td[i], rs, rd, er, cyc, qd);
      e = exp_q.pop_front();
      total++;
      if ({rd, er, cyc} !== {e.rd, e.err, e.cycles}) begin
        $display("FAIL b2b_%0d: got %h/%b/%0d want %h/%b/%0d", i, rd, er, cyc, e.rd, e.err, e.cycles);
        bad++;
      end
    end
    @(negedge clk);
    total++;
    if (s_proto !== 1'b0) begin $display("FAIL b2b_proto: got %b want 0", s_proto); bad++; end
  endtask

  task automatic test_out_of_range();
    logic [7:0] rs, rd, cyc; logic er; logic [127:0] qd, qexp; exp_t e;
    @(posedge clk); #1;
    cur = 0;
    qexp = model_flat(0);
    sb_push(1'b1, 8'h20, 8'h3C);
    xfer(1'b1, 8'h20, 8'h3C, rs, rd, er, cyc, qd);
    e = exp_q.pop_front();
    total++;
    if ({er, cyc} !== {e.err, e.cycles}) begin
      $display("FAIL oor_wr_resp: got err=%b cyc=%0d want err=%b cyc=%0d", er, cyc, e.err, e.cycles); bad++;
    end
    @(negedge clk);
    total++;
    if (s_regq !== qexp) begin $display("FAIL oor_wr_regq: got %h want %h", s_regq, qexp); bad++; end
    @(posedge clk); #1;
    sb_push(1'b0, 8'h20, 8'h00);
    xfer(1'b0, 8'h20, 8'h00, rs, rd, er, cyc, qd);
    e = exp_q.pop_front();
    total++;
    if ({rs, rd, er} !== {e.rd, e.rd, e.err}) begin
      $display("FAIL oor_rd: got setup=%h rd=%h err=%b want %h %h %b", rs, rd, er, e.rd, e.rd, e.err); bad++;
    end
  endtask

  task automatic test_wait_states();
    logic [7:0] rs, rd, cyc; logic er; logic [127:0] qd, qexp; exp_t e;
    @(posedge clk); #1;
    cur = 2;
    qexp = model_flat(2);
    sb_push(1'b1, 8'h01, 8'h11);
    xfer(1'b1, 8'h01, 8'h11, rs, rd, er, cyc, qd);
    e = exp_q.pop_front();
    total++;
    if (cyc !== e.cycles) begin $display("FAIL wait2_cycles: got %0d want %0d", cyc, e.cycles); bad++; end
    total++;
    if (er !== e.err) begin $display("FAIL wait2_err: got %b want %b", er, e.err); bad++; end
    total++;
    if (qd !== qexp) begin $display("FAIL wait2_early_write: got %h want %h", qd, qexp); bad++; end
    @(negedge clk);
    total++;
    if (s_regq[15:8] !== model[2][1]) begin
      $display("FAIL wait2_regq: got %h want %h", s_regq[15:8], model[2][1]); bad++;
    end
    total++;
    if (s_proto !== 1'b0) begin $display("FAIL wait2_proto: got %b want 0", s_proto); bad++; end
    @(posedge clk); #1;
    set_sel(1'b1); penable = 1'b0; pwrite = 1'b0; paddr = 8'h00;
    @(posedge clk); #1;
    set_sel(1'b0);
    @(posedge clk); #1;
    total++;
    if (s_proto !== 1'b1) begin $display("FAIL setup_no_access: got %b want 1", s_proto); bad++; end
  endtask

  task automatic test_protocol();
    logic [7:0] rs, rd, cyc; logic er; logic [127:0] qd; exp_t e;
    @(posedge clk); #1;
    cur = 0;
    set_sel(1'b1); penable = 1'b1; pwrite = 1'b0; paddr = 8'h02;
    @(negedge clk);
    total++;
    if (s_proto !== 1'b0) begin $display("FAIL proto_before: got %b want 0", s_proto); bad++; end
    @(posedge clk); #1;
    set_sel(1'b0); penable = 1'b0;
    total++;
    if (s_proto !== 1'b1) begin $display("FAIL proto_set: got %b want 1", s_proto); bad++; end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (s_proto !== 1'b1) begin $display("FAIL proto_sticky: got %b want 1", s_proto); bad++; end
    sb_push(1'b1, 8'h02, 8'h77);
    xfer(1'b1, 8'h02, 8'h77, rs, rd, er, cyc, qd);
    e = exp_q.pop_front();
    total++;
    if ({er, cyc} !== {e.err, e.cycles}) begin
      $display("FAIL proto_wr_resp: got err=%b cyc=%0d want err=%b cyc=%0d", er, cyc, e.err, e.cycles); bad++;
    end
    @(negedge clk);
    total++;
    if ({s_regq[23:16], s_proto} !== {model[0][2], 1'b1}) begin
      $display("FAIL proto_wr_lands: got %h/%b want %h/1", s_regq[23:16], s_proto, model[0][2]); bad++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rs, rd, cyc; logic er; logic [127:0] qd; exp_t e;
    @(posedge clk); #1;
    cur = 3;
    sb_push(1'b1, 8'h00, 8'h42);
    xfer(1'b1, 8'h00, 8'h42, rs, rd, er, cyc, qd);
    e = exp_q.pop_front();
    total++;
    if ({er, cyc} !== {e.err, e.cycles}) begin
      $display("FAIL wait3_resp: got err=%b cyc=%0d want err=%b cyc=%0d", er, cyc, e.err, e.cycles); bad++;
    end
    @(negedge clk);
    total++;
    if (s_regq[7:0] !== model[3][0]) begin
      $display("FAIL wait3_regq: got %h want %h", s_regq[7:0], model[3][0]); bad++;
    end
    @(posedge clk); #1;
    set_sel(1'b1); penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hFF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    total++;
    if (s_pready !== 1'b0) begin $display("FAIL wait3_stall: got pready=%b want 0", s_pready); bad++; end
    @(posedge clk); #1;
    pwdata = 8'hEE;
    @(posedge clk); #1;
    total++;
    if (s_proto !== 1'b1) begin $display("FAIL ctrl_change: got %b want 1", s_proto); bad++; end
    rst3 = 1'b1;
    for (int i = 0; i < 16; i++) model[3][i] = 8'h00;
    #1;
    total++;
    if ({s_pready, s_pslverr, s_proto} !== 3'b000) begin
      $display("FAIL midrst_flags: got pready=%b pslverr=%b proto=%b want 000", s_pready, s_pslverr, s_proto);
      bad++;
    end
    total++;
    if (s_regq !== model_flat(3)) begin
      $display("FAIL midrst_regq: got %h want %h", s_regq, model_flat(3)); bad++;
    end
    total++;
    if (u_dut3.r_state !== IDLE) begin
      $display("FAIL midrst_state: got %0d want %0d", u_dut3.r_state, IDLE); bad++;
    end
    @(negedge clk);
    total++;
    if (s_pready !== 1'b0) begin $display("FAIL midrst_hold: got pready=%b want 0", s_pready); bad++; end
    set_sel(1'b0); penable = 1'b0;
    @(posedge clk); #1;
    rst3 = 1'b0;
    @(posedge clk); #1;
    sb_push(1'b1, 8'h03, 8'h99);
    xfer(1'b1, 8'h03, 8'h99, rs, rd, er, cyc, qd);
    e = exp_q.pop_front();
    total++;
    if ({er, cyc} !== {e.err, e.cycles}) begin
      $display("FAIL post_rst_wr: got err=%b cyc=%0d want err=%b cyc=%0d", er, cyc, e.err, e.cycles); bad++;
    end
    sb_push(1'b0, 8'h03, 8'h00);
    xfer(1'b0, 8'h03, 8'h00, rs, rd, er, cyc, qd);
    e = exp_q.pop_front();
    total++;
    if ({rd, er, cyc} !== {e.rd, e.err, e.cycles}) begin
      $display("FAIL post_rst_rd: got %h/%b/%0d want %h/%b/%0d", rd, er, cyc, e.rd, e.err, e.cycles); bad++;
    end
    @(negedge clk);
    total++;
    if ({s_regq, s_proto} !== {model_flat(3), 1'b0}) begin
      $display("FAIL post_rst_state: got %h/%b want %h/0", s_regq, s_proto, model_flat(3)); bad++;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_out_of_range();
    test_wait_states();
    test_protocol();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1, "watchdog");
  end
endmodule
